mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the MMIO port of the CPU data-memory crossbar.
//  Takes the crossbar's MMIO word address, data, byte mask and write enable.
//  Queues written bytes in a small FIFO and serialises them as 8N1, LSB first, on o_tx.
//  Returns register read data one cycle after the address, matching the crossbar's registered read mux.
// PARAMETERS
//  FIFO_DEPTH   16      TX FIFO entries; power of two, >=2
//  DIV_RESET    867     reset value of DIVISOR; bit period = DIVISOR+1 clk cycles
// PORTS
//  clk      in   1   clock; all state updates on posedge
//  rst_n    in   1   asynchronous, active-low reset
//  i_addr   in   30  word offset inside MMIO window (already rebased by crossbar)
//  i_data   in   32  write data
//  i_wren   in   1   write strobe, one cycle per store
//  i_mask   in   4   byte-lane enables for writes
//  o_data   out  32  read data for the address presented on the previous cycle
//  o_tx     out  1   serial line, idle high
//  o_irq    out  1   level: FIFO empty and transmitter idle (all bytes sent)
// BEHAVIOUR
//  Register map (word offsets):
//   0 TXDATA   W: if i_mask[0], push i_data[7:0]; R: 0
//   1 STATUS   R: {27'b0, ovf, busy, full, empty, idle}; W: if i_mask[0] and i_data[4], clear ovf (W1C)
//   2 DIVISOR  R/W 16 bits in [15:0]; lanes 0/1 are written per i_mask[0]/[1]; [31:16] read 0
//   other offsets: read 0, writes ignored
//  Reset: o_data=0, o_tx=1, o_irq=1, FIFO empty, ovf=0, DIVISOR=DIV_RESET, FSM=IDLE.
//  Read latency: o_data registers the decode of i_addr and updates every cycle regardless of i_wren.
//   The register value is sampled at the address cycle, before that cycle's write takes effect.
//  Push: accepted iff FIFO is not full at the start of the cycle, even if a pop happens in the same cycle.
//   A rejected push sets ovf (sticky). Push and W1C in one cycle cannot occur, because they use different offsets.
//  FSM states: IDLE, START, DATA, STOP. A baud counter reloads to DIVISOR on each bit start and counts down to 0.
//   IDLE:  o_tx=1. If FIFO is non-empty, pop into the shift register and go to START with the counter loaded.
//   START: o_tx=0 for DIVISOR+1 cycles, then DATA with bit index 0.
//   DATA:  o_tx=shift[0] for one bit period each. Shift right; after bit 7 go to STOP.
//   STOP:  o_tx=1 for one bit period. At the end: if FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
//  busy = (state != IDLE). idle = !busy. empty/full come from the FIFO count.
//  A DIVISOR write mid-frame takes effect at the next bit boundary; the current bit keeps its length.
//  DIVISOR=0 gives 1-cycle bits (legal).
//  FIFO pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
//  Reset asserted mid-frame: o_tx goes to 1 immediately (asynchronously) and queued bytes are discarded.
// STRUCTURE
//  mmio_uart_defs.vh: register offsets (REG_TXDATA=0, REG_STATUS=1, REG_DIVISOR=2), STATUS bit positions, FSM state encodings.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/count, first-word-fall-through read.
//  Top level holds the register file, the read-data register, the baud counter and the TX FSM.
// TESTING
//  1 Reset: hold rst_n=0 -> o_tx=1, o_irq=1. Read off 2 -> 867 on the following cycle. Read off 1 -> 0x3 (empty|idle).
//  2 Write DIVISOR=3, then TXDATA=0xA5 -> o_tx sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1.
//    The frame is 40 cycles; o_irq=1 at the end of the stop bit.
//  3 Push 3 bytes back-to-back with DIVISOR=1 -> three 20-cycle frames, no idle cycle between stop and next start.
//  4 Hold the transmitter busy with a long DIVISOR, push 17 bytes -> byte 17 dropped and ovf=1 (STATUS bit4).
//    Write 0x10 to off 1 -> ovf=0. Exactly 16 bytes are transmitted.
//  5 i_mask=4'b0000 write to off 0 -> no push. i_mask=4'b0010 write 0x1200 to off 2 (DIVISOR=3) -> DIVISOR=0x1203.
//  6 Drop rst_n during DATA bit 4 -> o_tx=1 with no clk edge, FIFO empty.
//    After release, a new byte transmits cleanly. Read of off 7 -> 0.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register map, STATUS layout, TX FSM states.
package mmio_uart_tx_pkg;

  localparam int unsigned REG_TXDATA  = 0;
  localparam int unsigned REG_STATUS  = 1;
  localparam int unsigned REG_DIVISOR = 2;

  localparam int unsigned ST_IDLE  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_FULL  = 2;
  localparam int unsigned ST_BUSY  = 3;
  localparam int unsigned ST_OVF   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  // Member order gives ovf at bit 4 down to idle at bit 0.
  typedef struct packed {
    logic ovf;
    logic busy;
    logic full;
    logic empty;
    logic idle;
  } status_t;

  function automatic logic [31:0] status_word(input status_t s);
    return {27'b0, s};
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register file, registered read mux, TX FIFO, baud counter and 8N1 serialiser.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          sel_tx, sel_st, sel_div;
  logic          wr_txdata, busy;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  status_t       status;
  logic          unused_ok;

  assign sel_tx    = (i_addr == 30'(REG_TXDATA));
  assign sel_st    = (i_addr == 30'(REG_STATUS));
  assign sel_div   = (i_addr == 30'(REG_DIVISOR));
  assign wr_txdata = i_wren && sel_tx && i_mask[0];
  assign fifo_push = wr_txdata && !fifo_full;
  assign busy      = (state_q != S_IDLE);
  assign unused_ok = ^{i_data[31:16], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (i_data[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register writes and read decode; reads see pre-write values of the same cycle.
  always_comb begin
    div_d = div_q;
    if (i_wren && sel_div) begin
      if (i_mask[0]) div_d[7:0]  = i_data[7:0];
      if (i_mask[1]) div_d[15:8] = i_data[15:8];
    end

    ovf_d = ovf_q;
    if (wr_txdata && fifo_full)
      ovf_d = 1'b1;
    else if (i_wren && sel_st && i_mask[0] && i_data[ST_OVF])
      ovf_d = 1'b0;

    status = '{ovf: ovf_q, busy: busy, full: fifo_full, empty: fifo_empty, idle: !busy};

    rdata_d = '0;
    if (sel_st)
      rdata_d = status_word(status);
    else if (sel_div)
      rdata_d = {16'h0000, div_q};
  end

  // Counter reloads from the live DIVISOR only at bit boundaries, so a write never stretches the current bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = div_q;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7)
            state_d = S_STOP;
          else
            bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = div_q;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level decoded straight from reset-cleared state so reset forces it high without a clock.
  always_comb begin
    o_tx = 1'b1;
    unique case (state_q)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = shift_q[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_irq  = fifo_empty && !busy;
  assign o_data = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= DIV_RESET;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-level reference model compared every cycle, plus directed literals.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] i_addr = '0;
  logic [31:0] i_data = '0;
  logic        i_wren = 1'b0;
  logic [3:0]  i_mask = '0;
  logic [31:0] o_data;
  logic        o_tx;
  logic        o_irq;

  int compared = 0;
  int mismatched = 0;
  int unsigned cyc_cnt = 0;
  int unsigned n_falls = 0;

  mmio_uart_tx #(
    .FIFO_DEPTH (16),
    .DIV_RESET  (16'd867)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr (i_addr),
    .i_data (i_data),
    .i_wren (i_wren),
    .i_mask (i_mask),
    .o_data (o_data),
    .o_tx   (o_tx),
    .o_irq  (o_irq)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_cnt++; end
  initial forever begin @(negedge o_tx); if (rst_n) n_falls++; end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the frame being sent, viewed as ten bits of (DIVISOR+1) cycles each.
  logic [7:0]  mq[$];
  bit          m_act = 1'b0;
  int          m_bit = 0;
  int          m_rem = 0;
  logic [9:0]  m_frame = '1;
  logic [15:0] m_div = 16'd867;
  logic        m_ovf = 1'b0;
  logic [31:0] m_data = '0;

  initial forever begin : model
    int qs;
    logic [15:0] dv;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
      m_div = 16'd867;
      m_data = '0;
    end else begin
      qs = mq.size();
      dv = m_div;
      if (i_addr == 30'd1)
        m_data = {27'b0, m_ovf, m_act, qs == 16, qs == 0, !m_act};
      else if (i_addr == 30'd2)
        m_data = {16'b0, dv};
      else
        m_data = '0;

      if (m_act) begin
        if (m_rem == 1) begin
          if (m_bit == 9) begin
            if (qs > 0) begin
              m_frame = {1'b1, mq.pop_front(), 1'b0};
              m_bit = 0;
              m_rem = int'(dv) + 1;
            end else begin
              m_act = 1'b0;
            end
          end else begin
            m_bit++;
            m_rem = int'(dv) + 1;
          end
        end else begin
          m_rem--;
        end
      end else if (qs > 0) begin
        m_frame = {1'b1, mq.pop_front(), 1'b0};
        m_bit = 0;
        m_rem = int'(dv) + 1;
        m_act = 1'b1;
      end

      if (i_wren && i_addr == 30'd0 && i_mask[0]) begin
        if (qs < 16) mq.push_back(i_data[7:0]);
        else m_ovf = 1'b1;
      end
      if (i_wren && i_addr == 30'd1 && i_mask[0] && i_data[4]) m_ovf = 1'b0;
      if (i_wren && i_addr == 30'd2) begin
        if (i_mask[0]) m_div[7:0] = i_data[7:0];
        if (i_mask[1]) m_div[15:8] = i_data[15:8];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("tx", 32'(o_tx), 32'(m_act ? m_frame[m_bit] : 1'b1));
      chk("irq", 32'(o_irq), 32'(!m_act && mq.size() == 0));
      chk("rdata", o_data, m_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    i_addr = a; i_data = d; i_mask = m; i_wren = 1'b1;
    cyc();
    i_wren = 1'b0;
  endtask

  task automatic rd(input string name, input logic [29:0] a, input logic [31:0] exp);
    i_addr = a; i_wren = 1'b0;
    cyc();
    chk(name, o_data, exp);
  endtask

  task automatic wait_irq(input int budget, output int unsigned at);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_irq) begin ok = 1'b1; break; end
      cyc();
    end
    chk("irq_wait", 32'(ok), 32'd1);
    at = cyc_cnt;
  endtask

  initial begin : main
    int unsigned p, t, f0;
    logic [7:0] seq [10];
    logic [9:0] exp_seq;

    repeat (3) cyc();
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_irq", 32'(o_irq), 32'd1);
    chk("rst_data", o_data, 32'd0);
    rst_n = 1'b1;
    rd("rst_div", 30'd2, 32'd867);
    rd("rst_status", 30'd1, 32'h3);

    // 0xA5 at DIVISOR=3: one sample mid-bit per 4-cycle bit.
    wr(30'd2, 32'd3, 4'b0011);
    wr(30'd0, 32'hA5, 4'b0001);
    p = cyc_cnt;
    repeat (3) cyc();
    for (int k = 0; k < 10; k++) begin
      seq[k] = {7'b0, o_tx};
      if (k < 9) repeat (4) cyc();
    end
    exp_seq = 10'b11_0100_1010;
    for (int k = 0; k < 10; k++) chk($sformatf("a5_bit%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
    wait_irq(200, t);
    chk("a5_frame_len", t - p - 1, 32'd40);

    // Three back-to-back bytes at DIVISOR=1.
    wr(30'd2, 32'd1, 4'b0011);
    i_addr = 30'd0; i_mask = 4'b0001; i_wren = 1'b1; i_data = 32'h3C;
    cyc();
    p = cyc_cnt;
    i_data = 32'h81; cyc();
    i_data = 32'h5A; cyc();
    i_wren = 1'b0;
    wait_irq(300, t);
    chk("burst3_len", t - p - 1, 32'd60);

    // Overflow: transmitter busy, then 17 pushes of 0xFF; only start bits fall.
    wr(30'd2, 32'd20, 4'b0011);
    f0 = n_falls;
    wr(30'd0, 32'hFF, 4'b0001);
    repeat (3) cyc();
    i_addr = 30'd0; i_mask = 4'b0001; i_data = 32'hFF; i_wren = 1'b1;
    repeat (17) cyc();
    i_wren = 1'b0;
    rd("ovf_status", 30'd1, 32'h1C);
    wr(30'd1, 32'h10, 4'b0001);
    rd("ovf_cleared", 30'd1, 32'h0C);
    wait_irq(5000, t);
    chk("frames_sent", n_falls - f0, 32'd17);

    // Byte-lane masks.
    wr(30'd0, 32'h55, 4'b0000);
    rd("mask0_nopush", 30'd1, 32'h3);
    wr(30'd2, 32'd3, 4'b0011);
    wr(30'd2, 32'h1200, 4'b0010);
    rd("div_lane1", 30'd2, 32'h1203);
    wr(30'd2, 32'd3, 4'b0011);

    // Reset during DATA bit 4 (0x0F has bit4 = 0).
    wr(30'd0, 32'h0F, 4'b0001);
    wr(30'd0, 32'h33, 4'b0001);
    wr(30'd0, 32'h44, 4'b0001);
    repeat (20) cyc();
    chk("bit4_low", 32'(o_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", 32'(o_tx), 32'd1);
    chk("async_irq", 32'(o_irq), 32'd1);
    repeat (2) cyc();
    rst_n = 1'b1;
    rd("post_rst_status", 30'd1, 32'h3);
    rd("post_rst_div", 30'd2, 32'd867);
    wr(30'd2, 32'd2, 4'b0011);
    wr(30'd0, 32'hC3, 4'b0001);
    wait_irq(200, t);
    rd("off7", 30'd7, 32'd0);

    // Randomised traffic with small divisors; the model checks every cycle.
    wr(30'd2, 32'd1, 4'b0011);
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      i_wren = 1'b0;
      if (r < ((n < 1800) ? 35 : 8)) begin
        i_addr = 30'd0; i_data = $urandom; i_wren = 1'b1;
        i_mask = ($urandom_range(0, 9) < 8) ? 4'(($urandom & 4'hE) | 4'h1) : 4'($urandom);
      end else if (r < 40) begin
        i_addr = 30'd1; i_data = $urandom; i_mask = 4'($urandom); i_wren = 1'b1;
      end else if (r < 42) begin
        i_addr = 30'd2; i_wren = 1'b1; i_mask = 4'($urandom);
        i_data = {16'($urandom), 16'($urandom_range(0, 3))};
      end else if (r < 44) begin
        i_addr = 30'($urandom_range(3, 1000)); i_data = $urandom; i_mask = 4'($urandom); i_wren = 1'b1;
      end else begin
        i_addr = ($urandom_range(0, 1) == 0) ? 30'($urandom_range(0, 3)) : 30'($urandom);
      end
      cyc();
    end
    i_wren = 1'b0;
    wait_irq(3000, t);
    rd("final_status_idle", 30'd1, {27'b0, m_ovf, 4'b0011});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
